pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_pkg.sv | 32 +++
 rtl/ret_stack.sv | 62 ++++++
 rtl/pc_seq.sv | 107 ++++++++++
 tb/tb_pc_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: default parameters,
// the command encoding and the priority decode that turns request lines into
// a single command.
package pc_pkg;

    localparam int DEF_WIDTH   = 10;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_STEP    = 1;
    localparam int DEF_RST_VAL = 0;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_STEP = 3'd1,
        CMD_BR   = 3'd2,
        CMD_JMP  = 3'd3,
        CMD_CALL = 3'd4,
        CMD_RET  = 3'd5
    } cmd_e;

    // Fixed priority ret > call > jmp > br > step; en low freezes everything.
    function automatic cmd_e cmd_decode(input logic en, input logic ret,
                                        input logic call, input logic jmp,
                                        input logic br);
        if (!en)  return CMD_HOLD;
        if (ret)  return CMD_RET;
        if (call) return CMD_CALL;
        if (jmp)  return CMD_JMP;
        if (br)   return CMD_BR;
        return CMD_STEP;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Purpose: LIFO of return addresses for pc_seq (DEPTH entries of WIDTH bits).
// Latency: push/pop take effect at the clock edge; top_data/full/empty follow the registered pointer.
// Backpressure: push when full and pop when empty are ignored; the caller flags the error.
// Ports: clk, rst (async active-low), push, pop, push_data -> top_data, full, empty.
module ret_stack import pc_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    // Pointer counts entries 0..DEPTH inclusive, hence DEPTH+1 states.
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;
    logic [IW-1:0]    wr_idx, rd_idx;

    assign full    = (ptr_q == PW'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    // Next free slot is at ptr; top of stack is one below it.
    assign wr_idx   = IW'(ptr_q);
    assign rd_idx   = IW'(ptr_q - PW'(1));
    assign top_data = mem_q[rd_idx];

    always_comb begin
        ptr_d = ptr_q;
        if (do_push) begin
            ptr_d = ptr_q + PW'(1);
        end else if (do_pop) begin
            ptr_d = ptr_q - PW'(1);
        end
    end

    // Reset only clears the pointer; stale entries are unreachable afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Purpose: program counter with step up/down, jump, relative branch and call/return stack.
// Latency: one cycle from command edge to ctr_out and flags; no input-to-output combinational path.
// Backpressure: none; en=0 freezes counter, stack and flags (err_clr still acts).
// Ports: clk, rst (async active-low), en, dir, jmp/jmp_loc, br/br_off, call, ret, err_clr
//        -> ctr_out, stk_full, stk_empty, stk_err (sticky overflow/underflow).
module pc_seq import pc_pkg::*; #(
    parameter int          WIDTH   = DEF_WIDTH,
    parameter int          DEPTH   = DEF_DEPTH,
    parameter int          STEP    = DEF_STEP,
    parameter int unsigned RST_VAL = DEF_RST_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_loc,
    input  logic             br,
    input  logic [WIDTH-1:0] br_off,
    input  logic             call,
    input  logic             ret,
    input  logic             err_clr,
    output logic [WIDTH-1:0] ctr_out,
    output logic             stk_full,
    output logic             stk_empty,
    output logic             stk_err
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);

    cmd_e             cmd;
    logic [WIDTH-1:0] ctr_q, ctr_d;
    logic [WIDTH-1:0] step_val, ret_addr, top_data;
    logic             err_q, err_d, err_set;
    logic             push, pop, full, empty;

    assign cmd = cmd_decode(en, ret, call, jmp, br);

    always_comb begin
        step_val = dir ? (ctr_q + STEP_W) : (ctr_q - STEP_W);
        // Return address is always the next sequential slot, whatever dir says.
        ret_addr = ctr_q + STEP_W;
        ctr_d    = ctr_q;
        push     = 1'b0;
        pop      = 1'b0;
        err_set  = 1'b0;
        case (cmd)
            CMD_RET: begin
                if (!empty) begin
                    pop   = 1'b1;
                    ctr_d = top_data;
                end else begin
                    // Underflow degrades to an ordinary step.
                    err_set = 1'b1;
                    ctr_d   = step_val;
                end
            end
            CMD_CALL: begin
                if (!full) begin
                    push  = 1'b1;
                    ctr_d = jmp_loc;
                end else begin
                    // Overflow degrades to an ordinary step.
                    err_set = 1'b1;
                    ctr_d   = step_val;
                end
            end
            CMD_JMP:  ctr_d = jmp_loc;
            CMD_BR:   ctr_d = ctr_q + br_off;
            CMD_STEP: ctr_d = step_val;
            default:  ctr_d = ctr_q;
        endcase
        // A new error outranks a simultaneous clear.
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q <= RST_W;
            err_q <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            err_q <= err_d;
        end
    end

    ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top_data  (top_data),
        .full      (full),
        .empty     (empty)
    );

    assign ctr_out   = ctr_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq at default parameters (WIDTH=10, DEPTH=4, STEP=1, RST_VAL=0):
// directed vector table, hand-written reset and stack-limit sequences, then
// random commands checked against a queue-based reference model.
module tb_pc_seq;

    logic       clk;
    logic       rst;
    logic       en, dir, jmp, br, call, ret, err_clr;
    logic [9:0] jmp_loc, br_off;
    logic [9:0] ctr_out;
    logic       stk_full, stk_empty, stk_err;

    int checks = 0;
    int errors = 0;

    pc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .jmp       (jmp),
        .jmp_loc   (jmp_loc),
        .br        (br),
        .br_off    (br_off),
        .call      (call),
        .ret       (ret),
        .err_clr   (err_clr),
        .ctr_out   (ctr_out),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, dir, jmp;
        logic [9:0] loc;
        logic       br;
        logic [9:0] off;
        logic       call, ret, clr;
        int         e_ctr;
        bit         e_full, e_empty, e_err;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: counter value, stack as a queue, sticky error.
    int m_ctr;
    int m_stk[$];
    bit m_err;

    function automatic vec_t mk(input logic en_, dir_, jmp_, input int loc_,
                                input logic br_, input int off_,
                                input logic call_, ret_, clr_,
                                input int ectr, input bit efull, eempty, eerr);
        vec_t v;
        v.en = en_; v.dir = dir_; v.jmp = jmp_; v.loc = loc_[9:0];
        v.br = br_; v.off = off_[9:0]; v.call = call_; v.ret = ret_; v.clr = clr_;
        v.e_ctr = ectr; v.e_full = efull; v.e_empty = eempty; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, what, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        en = v.en; dir = v.dir; jmp = v.jmp; jmp_loc = v.loc; br = v.br;
        br_off = v.off; call = v.call; ret = v.ret; err_clr = v.clr;
    endtask

    task automatic idle();
        en = 0; dir = 1; jmp = 0; jmp_loc = 0; br = 0; br_off = 0;
        call = 0; ret = 0; err_clr = 0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v);
        @(posedge clk);
        #1;
        chk(tag, "ctr",   ctr_out,   v.e_ctr);
        chk(tag, "full",  stk_full,  v.e_full);
        chk(tag, "empty", stk_empty, v.e_empty);
        chk(tag, "err",   stk_err,   v.e_err);
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    // Behavioural rules: priority ret > call > jmp > br > step, arithmetic mod 1024.
    task automatic model_step(input logic men, mdir, mjmp, input int mloc,
                              input logic mbr, input int moff,
                              input logic mcall, mret, mclr);
        bit eset = 0;
        int stepv = mdir ? (m_ctr + 1) % 1024 : (m_ctr + 1023) % 1024;
        if (men) begin
            if (mret) begin
                if (m_stk.size() > 0) m_ctr = m_stk.pop_back();
                else begin eset = 1; m_ctr = stepv; end
            end else if (mcall) begin
                if (m_stk.size() < 4) begin
                    m_stk.push_back((m_ctr + 1) % 1024);
                    m_ctr = mloc;
                end else begin eset = 1; m_ctr = stepv; end
            end else if (mjmp) m_ctr = mloc;
            else if (mbr) m_ctr = (m_ctr + moff) % 1024;
            else m_ctr = stepv;
        end
        if (eset) m_err = 1;
        else if (mclr) m_err = 0;
    endtask

    initial begin
        int pops[4] = '{121, 111, 101, 1};
        vec_t v;

        // Table: en,dir,jmp,loc,br,off,call,ret,clr -> ctr,full,empty,err
        for (int i = 1; i <= 10; i++) tbl.push_back(mk(1,1,0,0,0,0,0,0,0, i,0,1,0));
        tbl.push_back(mk(1,1,0,0,  1,1021,0,0,0,  7,   0,1,0)); // br -3
        tbl.push_back(mk(1,1,1,0,  0,0,   0,0,0,  0,   0,1,0));
        tbl.push_back(mk(1,0,0,0,  0,0,   0,0,0,  1023,0,1,0)); // wrap down
        tbl.push_back(mk(0,1,1,55, 0,0,   0,0,0,  1023,0,1,0)); // en=0 holds
        tbl.push_back(mk(1,1,1,20, 0,0,   0,0,0,  20,  0,1,0));
        tbl.push_back(mk(1,1,1,69, 0,0,   0,0,0,  69,  0,1,0));
        tbl.push_back(mk(1,1,0,0,  0,0,   0,0,0,  70,  0,1,0));
        tbl.push_back(mk(1,1,1,5,  0,0,   0,0,0,  5,   0,1,0));
        tbl.push_back(mk(1,1,0,200,0,0,   1,0,0,  200, 0,0,0)); // call pushes 6
        tbl.push_back(mk(1,1,0,0,  0,0,   0,0,0,  201, 0,0,0));
        tbl.push_back(mk(1,1,0,0,  0,0,   0,0,0,  202, 0,0,0));
        tbl.push_back(mk(1,1,0,0,  0,0,   0,1,0,  6,   0,1,0)); // ret
        tbl.push_back(mk(1,1,0,0,  0,0,   0,1,0,  7,   0,1,1)); // underflow steps
        tbl.push_back(mk(0,1,0,0,  0,0,   0,0,1,  7,   0,1,0)); // clr while en=0
        tbl.push_back(mk(1,1,1,299,0,0,   0,0,0,  299, 0,1,0));
        tbl.push_back(mk(1,1,0,10, 0,0,   1,0,0,  10,  0,0,0)); // pushes 300
        tbl.push_back(mk(1,1,1,500,0,0,   1,1,0,  300, 0,1,0)); // ret wins
        tbl.push_back(mk(1,1,0,0,  0,0,   0,1,1,  301, 0,1,1)); // err beats clr
        tbl.push_back(mk(0,1,0,0,  0,0,   0,0,1,  301, 0,1,0));
        tbl.push_back(mk(1,1,1,40, 1,5,   0,0,0,  40,  0,1,0)); // jmp beats br
        tbl.push_back(mk(1,0,0,0,  1,5,   0,0,0,  45,  0,1,0)); // br ignores dir
        tbl.push_back(mk(1,0,0,0,  0,0,   0,0,0,  44,  0,1,0));

        // Reset values visible without any clock edge.
        idle();
        rst = 0;
        #2;
        chk("rst0", "ctr",   ctr_out,   0);
        chk("rst0", "full",  stk_full,  0);
        chk("rst0", "empty", stk_empty, 1);
        chk("rst0", "err",   stk_err,   0);
        @(posedge clk);
        #1;
        rst = 1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Asynchronous reset mid-cycle discards stacked entries.
        do_reset();
        apply(mk(1,1,0,4,0,0,1,0,0, 4,0,0,0), "arst.call");
        apply(mk(1,1,0,0,0,0,0,0,0, 5,0,0,0), "arst.step");
        idle();
        #3;
        rst = 0;
        #1;
        chk("arst", "ctr",   ctr_out,   0);
        chk("arst", "empty", stk_empty, 1);
        chk("arst", "full",  stk_full,  0);
        chk("arst", "err",   stk_err,   0);
        @(posedge clk);
        #1;
        rst = 1;
        apply(mk(1,1,0,0,0,0,0,1,0, 1,0,1,1), "arst.ret_after");

        // Fill and overflow, then drain and underflow.
        do_reset();
        for (int i = 0; i < 4; i++)
            apply(mk(1,1,0,100+10*i,0,0,1,0,0, 100+10*i, i==3, 0, 0),
                  $sformatf("ovf.call%0d", i));
        apply(mk(1,1,0,900,0,0,1,0,0, 131,1,0,1), "ovf.call4");
        apply(mk(0,1,0,0,0,0,0,0,1, 131,1,0,0), "ovf.clr");
        for (int i = 0; i < 4; i++)
            apply(mk(1,1,0,0,0,0,0,1,0, pops[i], 0, i==3, 0), $sformatf("ovf.ret%0d", i));
        apply(mk(1,1,0,0,0,0,0,1,0, 2,0,1,1), "ovf.ret4");
        apply(mk(1,1,0,0,0,0,0,0,1, 3,0,1,0), "ovf.clr2");

        // Random commands against the reference model.
        do_reset();
        m_ctr = 0;
        m_stk.delete();
        m_err = 0;
        for (int n = 0; n < 3000; n++) begin
            v.en   = ($urandom_range(7) != 0);
            v.dir  = $urandom_range(1);
            v.jmp  = ($urandom_range(5) == 0);
            v.loc  = 10'($urandom);
            v.br   = ($urandom_range(5) == 0);
            v.off  = 10'($urandom);
            v.call = ($urandom_range(4) == 0);
            v.ret  = ($urandom_range(4) == 0);
            v.clr  = ($urandom_range(7) == 0);
            model_step(v.en, v.dir, v.jmp, int'(v.loc), v.br, int'(v.off),
                       v.call, v.ret, v.clr);
            v.e_ctr   = m_ctr;
            v.e_full  = (m_stk.size() == 4);
            v.e_empty = (m_stk.size() == 0);
            v.e_err   = m_err;
            apply(v, $sformatf("rnd[%0d]", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
